// File: rtl/dpram_be_pkg.sv
// ---------------------------------------------------------------------------
// dpram_be_pkg
// Shared types and helpers for the byte-enabled dual-port RAM (dpram_be).
//   state_e   : clear-walk FSM states (CLEAR while initialising, READY after)
//   byte_mask : expands one byte-enable bit into an 8-bit lane mask
// ---------------------------------------------------------------------------
package dpram_be_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // One byte-enable bit covers a full 8-bit lane of the data word.
    function automatic logic [7:0] byte_mask(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/dpram_be_lane.sv
// ---------------------------------------------------------------------------
// dpram_be_lane
// One 8-bit-wide true dual-port storage slice. Each port has a single write
// enable; reads are asynchronous (the parent registers the read data).
// The parent guarantees the two ports never write the same address in the
// same cycle.
//   clock          : write clock (posedge)
//   we_x           : write enable for port x
//   addr_x         : address for port x
//   din_x / dout_x : write data / combinational read data for port x
// ---------------------------------------------------------------------------
module dpram_be_lane
    import dpram_be_pkg::*;
#(
    parameter int WIDTHAD = 8
) (
    input  logic               clock,
    input  logic               we_a,
    input  logic [WIDTHAD-1:0] addr_a,
    input  logic [7:0]         din_a,
    output logic [7:0]         dout_a,
    input  logic               we_b,
    input  logic [WIDTHAD-1:0] addr_b,
    input  logic [7:0]         din_b,
    output logic [7:0]         dout_b
);

    localparam int DEPTH = 2 ** WIDTHAD;

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents become defined only through
    // the clear walk, which keeps it mappable onto plain RAM resources.
    always_ff @(posedge clock) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    assign dout_a = mem[addr_a];
    assign dout_b = mem[addr_b];

endmodule

// File: rtl/dpram_be.sv
// ---------------------------------------------------------------------------
// dpram_be
// Byte-enabled true dual-port RAM with a power-up/on-demand clear walk.
// After reset (or a clear pulse while READY) every word is written with
// CLEAR_VAL, one per cycle, while busy is high; port requests are ignored
// during that time. Port A wins same-address write collisions; a read from
// one port sees the other port's same-cycle write merged per byte lane.
//
// Ports:
//   clock, reset_n          : clock (posedge), async active-low reset
//   clear / busy            : start clear walk / walk in progress
//   address_x, data_x       : address and write data, x in {a,b}
//   byteen_x                : per-byte write enable
//   wren_x, rden_x          : write request (has priority) / read request
//   q_x, valid_x            : read data and its one-cycle strobe
//   collision               : pulses when a port-B write was dropped
//
// Build option: define DPRAM_BE_OUTREG_EN to add an output register stage on
// q_x/valid_x (read latency 2 instead of 1).
// ---------------------------------------------------------------------------
module dpram_be
    import dpram_be_pkg::*;
#(
    parameter int               WIDTHAD   = 8,
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    output logic                 busy,
    input  logic [WIDTHAD-1:0]   address_a,
    input  logic [WIDTH-1:0]     data_a,
    input  logic [WIDTH/8-1:0]   byteen_a,
    input  logic                 wren_a,
    input  logic                 rden_a,
    output logic [WIDTH-1:0]     q_a,
    output logic                 valid_a,
    input  logic [WIDTHAD-1:0]   address_b,
    input  logic [WIDTH-1:0]     data_b,
    input  logic [WIDTH/8-1:0]   byteen_b,
    input  logic                 wren_b,
    input  logic                 rden_b,
    output logic [WIDTH-1:0]     q_b,
    output logic                 valid_b,
    output logic                 collision
);

    localparam int                 NBYTES    = WIDTH / 8;
    localparam logic [WIDTHAD-1:0] LAST_ADDR = '1;

    // ---------------- clear-walk FSM ----------------
    state_e             state_q,    state_d;
    logic [WIDTHAD-1:0] clr_addr_q, clr_addr_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLEAR: begin
                // Terminal-count detection: leave the walk on the last
                // address instead of letting the counter wrap.
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + WIDTHAD'(1);
                end
            end
            READY: begin
                if (clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
        endcase
    end

    logic ready;
    assign ready = (state_q == READY);
    assign busy  = ~ready;

    // ---------------- request decode ----------------
    logic a_wr, a_rd, b_wr_req, b_wr, b_rd, same_addr, coll;

    assign same_addr = (address_a == address_b);
    assign a_wr      = ready & wren_a & (|byteen_a);
    assign a_rd      = ready & rden_a & ~wren_a;
    assign b_wr_req  = ready & wren_b & (|byteen_b);
    assign b_rd      = ready & rden_b & ~wren_b;
    // Port B's write is dropped entirely when port A writes the same word.
    assign coll      = a_wr & b_wr_req & same_addr;
    assign b_wr      = b_wr_req & ~coll;

    // ---------------- storage lanes ----------------
    logic [WIDTH-1:0]   mask_a, mask_b;
    logic [WIDTH-1:0]   raw_a, raw_b;
    logic [NBYTES-1:0]  lane_we_a, lane_we_b;
    logic [WIDTHAD-1:0] lane_addr_a;
    logic [WIDTH-1:0]   lane_din_a;

    // The clear walk borrows port A of every lane.
    always_comb begin
        lane_we_a   = byteen_a & {NBYTES{a_wr}};
        lane_addr_a = address_a;
        lane_din_a  = data_a;
        if (!ready) begin
            lane_we_a   = '1;
            lane_addr_a = clr_addr_q;
            lane_din_a  = CLEAR_VAL;
        end
    end

    assign lane_we_b = byteen_b & {NBYTES{b_wr}};

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        assign mask_a[8*i +: 8] = byte_mask(byteen_a[i]);
        assign mask_b[8*i +: 8] = byte_mask(byteen_b[i]);

        dpram_be_lane #(
            .WIDTHAD (WIDTHAD)
        ) u_lane (
            .clock  (clock),
            .we_a   (lane_we_a[i]),
            .addr_a (lane_addr_a),
            .din_a  (lane_din_a[8*i +: 8]),
            .dout_a (raw_a[8*i +: 8]),
            .we_b   (lane_we_b[i]),
            .addr_b (address_b),
            .din_b  (data_b[8*i +: 8]),
            .dout_b (raw_b[8*i +: 8])
        );
    end

    // ---------------- read path with cross-port bypass ----------------
    logic [WIDTH-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
    logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic             collision_q, collision_d;

    always_comb begin
        q_a_d       = q_a_q;
        q_b_d       = q_b_q;
        valid_a_d   = a_rd;
        valid_b_d   = b_rd;
        collision_d = coll;
        // A reader sees the opposite port's same-cycle write lane by lane.
        if (a_rd) begin
            q_a_d = raw_a;
            if (b_wr && same_addr) q_a_d = (raw_a & ~mask_b) | (data_b & mask_b);
        end
        if (b_rd) begin
            q_b_d = raw_b;
            if (a_wr && same_addr) q_b_d = (raw_b & ~mask_a) | (data_a & mask_a);
        end
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            q_a_q       <= '0;
            q_b_q       <= '0;
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            q_a_q       <= q_a_d;
            q_b_q       <= q_b_d;
            valid_a_q   <= valid_a_d;
            valid_b_q   <= valid_b_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

`ifdef DPRAM_BE_OUTREG_EN
    // Extra output stage: read data and strobe both arrive one cycle later.
    logic [WIDTH-1:0] q_a_o_q, q_b_o_q;
    logic             valid_a_o_q, valid_b_o_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_a_o_q     <= '0;
            q_b_o_q     <= '0;
            valid_a_o_q <= 1'b0;
            valid_b_o_q <= 1'b0;
        end else begin
            q_a_o_q     <= q_a_q;
            q_b_o_q     <= q_b_q;
            valid_a_o_q <= valid_a_q;
            valid_b_o_q <= valid_b_q;
        end
    end

    assign q_a     = q_a_o_q;
    assign q_b     = q_b_o_q;
    assign valid_a = valid_a_o_q;
    assign valid_b = valid_b_o_q;
`else
    assign q_a     = q_a_q;
    assign q_b     = q_b_q;
    assign valid_a = valid_a_q;
    assign valid_b = valid_b_q;
`endif

endmodule

// File: doc/dpram_be.md
DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 The block SHALL have parameter WIDTHAD, default 8, meaning address width; depth = 2**WIDTHAD words.
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning data width; it must be a multiple of 8, with NBYTES = WIDTH/8.
REQ-003 The block SHALL have parameter CLEAR_VAL, default 0 (WIDTH bits), meaning the word written by the clear walk.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on posedge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit, a pulse that starts a memory clear walk.
REQ-007 The block SHALL have port busy, output, 1 bit, high while the clear walk runs.
REQ-008 The block SHALL have, for each port x in {a,b}, port address_x, input, WIDTHAD bits.
REQ-009 The block SHALL have, for each port x, port data_x, input, WIDTH bits.
REQ-010 The block SHALL have, for each port x, port byteen_x, input, NBYTES bits, the per-byte write enable.
REQ-011 The block SHALL have, for each port x, ports wren_x and rden_x, inputs, 1 bit each.
REQ-012 The block SHALL have, for each port x, port q_x, output, WIDTH bits, the read data.
REQ-013 The block SHALL have, for each port x, port valid_x, output, 1 bit, a one-cycle pulse marking new q_x.
REQ-014 The block SHALL have port collision, output, 1 bit, pulsed when a port-B write was dropped.

Function
REQ-015 The block SHALL use clear-walk FSM states CLEAR and READY; in CLEAR it writes CLEAR_VAL to address 0..depth-1, one word per cycle, then goes to READY after the last address.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY; a clear pulse in READY enters CLEAR at address 0; a clear pulse during CLEAR is ignored.
REQ-017 While busy, all port requests SHALL be ignored: no writes, valid_x = 0, and q_x holds.
REQ-018 On each port, wren_x SHALL have priority over rden_x; a cycle with both set is a write only.
REQ-019 A write SHALL update only the byte lanes i where byteen_x[i]=1; byteen_x = 0 means no write.
REQ-020 A read SHALL have 1-cycle latency: q_x and valid_x update on the edge after rden_x is sampled; q_x holds its value between reads.
REQ-021 When both ports write the same address in the same cycle, port A's write SHALL take effect, port B's write SHALL be dropped entirely, and collision SHALL pulse for 1 cycle.
REQ-022 On a read-during-write from the opposite port to the same address, the read SHALL return new data per lane: (old & ~mask) | (new & mask), where mask is the writing port's byte-expanded byteen.
REQ-023 A port SHALL never read its own write in the same cycle, because priority per REQ-018 applies.
REQ-024 On the last clear address, the FSM SHALL transition to READY without wrap-around; the counter SHALL be WIDTHAD+1 bits wide or use explicit terminal-count detection.

Reset
REQ-025 On reset_n low, the block SHALL asynchronously set q_a = q_b = 0, valid_a = valid_b = 0, collision = 0, busy = 1, state = CLEAR, and clear address = 0.
REQ-026 On reset release, the clear walk SHALL start on the first clock edge.
REQ-027 Reset asserted mid-walk SHALL restart the walk from address 0.
REQ-028 Memory contents SHALL NOT be reset directly and SHALL be defined only through the clear walk.

Configuration
REQ-029 When DPRAM_BE_OUTREG_EN is defined, the block SHALL add an output register stage on q_x and valid_x, giving 2-cycle read latency.
REQ-030 When DPRAM_BE_OUTREG_EN is undefined, read latency SHALL be 1 cycle; all other behaviour is identical in both cases.

Structure
REQ-031 Package dpram_be_pkg SHALL hold the FSM state enum (CLEAR, READY) and the byte-mask expansion function.
REQ-032 Sub-module dpram_be_lane SHALL be one 8-bit-wide true dual-port storage slice with a single write enable per port, instantiated NBYTES times; bypass, collision and FSM logic SHALL stay in dpram_be.

Verification
REQ-033 The bench SHALL cover: release reset, WIDTHAD=4 -> busy high exactly 16 cycles, then every address reads CLEAR_VAL.
REQ-034 The bench SHALL cover: A writes 0xBEEF to addr 3 with byteen=2'b01, after memory holds 0x1234 -> B reads 0x12EF, valid_b pulses 1 cycle later.
REQ-035 The bench SHALL cover: A and B write addr 5 with 0xAAAA and 0x5555 in the same cycle -> addr 5 = 0xAAAA, collision pulses once.
REQ-036 The bench SHALL cover: A writes 0xFFFF with byteen=2'b10 to addr 7, which holds 0x0000, while B reads addr 7 -> q_b = 0xFF00.
REQ-037 The bench SHALL cover: reset_n pulsed low at clear address 9 -> q and valid go 0 immediately, and the walk restarts at 0 and takes the full 16 cycles.
REQ-038 The bench SHALL cover: with DPRAM_BE_OUTREG_EN defined, a read of addr 2 -> valid_a pulses 2 cycles after rden_a.
